// File: rtl/step_lane_scroller.sv
// DDR playfield note scroller: shifting LANES x DEPTH note grid, lane-scanned active-low LED
// output and hit/miss judgment on the last row. Optional saturating miss counter: STEP_MISS_CNT_EN.
module step_lane_scroller #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned MISS_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_step_en,
  input  logic [LANES-1:0]  i_input_step,
  input  logic [LANES-1:0]  i_hit_lane,
  output logic [LANES-1:0]  o_lane_sel,
  output logic [DEPTH-1:0]  o_col,
  output logic [LANES-1:0]  o_action_step,
  output logic [LANES-1:0]  o_hit_ok,
  output logic              o_miss_pulse
`ifdef STEP_MISS_CNT_EN
  ,
  output logic [MISS_W-1:0] o_miss_count
`endif
);

  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  generate
    if (LANES < 1 || DEPTH < 2 || SCAN_DIV < 1 || MISS_W < 1) begin : g_param_check
      $error("step_lane_scroller: illegal parameter value");
    end
  endgenerate

  logic [LANES-1:0] r_grid [DEPTH];
  logic [LANES-1:0] r_hit_ok;
  logic             r_miss_pulse;
  logic [IDX_W-1:0] r_idx;
  logic [DIV_W-1:0] r_div;
  logic [LANES-1:0] w_hit;
  logic [LANES-1:0] w_unhit;

  // Judgment always looks at the pre-shift judgment row.
  assign w_hit   = i_hit_lane & r_grid[DEPTH-1];
  assign w_unhit = r_grid[DEPTH-1] & ~i_hit_lane;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_grid[i] <= '0;
      r_hit_ok     <= '0;
      r_miss_pulse <= 1'b0;
    end else begin
      r_hit_ok     <= w_hit;
      r_miss_pulse <= i_step_en & (|w_unhit);
      if (i_step_en) begin
        r_grid[0] <= i_input_step;
        for (int i = 1; i < DEPTH; i++) r_grid[i] <= r_grid[i-1];
      end else begin
        r_grid[DEPTH-1] <= w_unhit;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_W'(LANES - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

`ifdef STEP_MISS_CNT_EN
  logic [MISS_W-1:0] r_miss_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_miss_count <= '0;
    end else if (r_miss_pulse && (r_miss_count != '1)) begin
      r_miss_count <= r_miss_count + 1'b1;
    end
  end

  assign o_miss_count = r_miss_count;
`endif

  // Row 0 sits at the top LED, i.e. the highest col bit.
  always_comb begin
    o_col = '1;
    for (int j = 0; j < DEPTH; j++) o_col[DEPTH-1-j] = ~r_grid[j][r_idx];
  end

  assign o_lane_sel    = LANES'(1) << r_idx;
  assign o_action_step = r_grid[DEPTH-1];
  assign o_hit_ok      = r_hit_ok;
  assign o_miss_pulse  = r_miss_pulse;

endmodule
